io_port_ctrl: RTL and testbench

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_port_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_io_port_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// ---------------------------------------------------------------------------
// io_port_ctrl
//
// Connects a stalling processor load/store port to a set of streaming I/O
// channels.
//   - Input side: each of NUIOIN channels has a one-entry buffer filled through
//     in_valid/in_ready. A processor read picks one channel. If the buffer is
//     empty, the processor stalls until data arrives or the timeout expires.
//   - Output side: each of NUIOOU channels has a one-entry register drained
//     through out_valid/out_ready. A processor write stalls while the target
//     register is full and is not being drained in the same cycle.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   proc_req_in         read request (held while proc_stall is high)
//   proc_addr_in        read channel index
//   proc_data_in        read data (zero unless a read completes this cycle)
//   proc_out_en         write request (held while proc_stall is high)
//   proc_addr_out       write channel index
//   proc_data_out       write data
//   proc_stall          processor must hold its current request
//   in_data/in_valid/in_ready     packed input channels and their handshake
//   out_data/out_valid/out_ready  packed output channels and their handshake
//   req_in              one-hot pulse, one cycle after each completed read
//   out_en              one-hot pulse, one cycle after each accepted write
//   err_addr, err_tmo   sticky address-range and read-timeout flags
// ---------------------------------------------------------------------------
module io_port_ctrl #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2,
    parameter int TMO    = 1024,
    localparam int AIW   = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int AOW   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     proc_req_in,
    input  logic [AIW-1:0]           proc_addr_in,
    output logic [NUBITS-1:0]        proc_data_in,
    input  logic                     proc_out_en,
    input  logic [AOW-1:0]           proc_addr_out,
    input  logic [NUBITS-1:0]        proc_data_out,
    output logic                     proc_stall,
    input  logic [NUIOIN*NUBITS-1:0] in_data,
    input  logic [NUIOIN-1:0]        in_valid,
    output logic [NUIOIN-1:0]        in_ready,
    output logic [NUIOOU*NUBITS-1:0] out_data,
    output logic [NUIOOU-1:0]        out_valid,
    input  logic [NUIOOU-1:0]        out_ready,
    output logic [NUIOIN-1:0]        req_in,
    output logic [NUIOOU-1:0]        out_en,
    output logic                     err_addr,
    output logic                     err_tmo
);

    localparam int CW = $clog2(TMO + 1);
    // The WAIT cycle that moves the counter onto TMO-1 is the last stalled
    // one, so a timed-out read stalls for exactly TMO cycles in total.
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_TOUT = 2'd2;

    logic [1:0]                     rd_state, rd_next;
    logic [CW-1:0]                  cnt, cnt_next;
    logic [NUIOIN-1:0][NUBITS-1:0]  ibuf;
    logic [NUIOIN-1:0]              ifull;
    logic [NUIOOU-1:0][NUBITS-1:0]  obuf;

    logic [NUIOIN-1:0]              rd_sel, consume;
    logic                           sel_full;
    logic [NUBITS-1:0]              sel_data;
    logic                           rd_stall, rd_done, rd_err_addr, rd_err_tmo;
    logic [NUBITS-1:0]              rd_data;

    logic [NUIOOU-1:0]              wr_acc;
    logic                           wr_hit, wr_stall, wr_err_addr;

    // Decode the read address into a one-hot channel select; an address with
    // no matching channel leaves rd_sel all-zero and counts as out of range.
    always_comb begin
        rd_sel   = '0;
        sel_full = 1'b0;
        sel_data = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (proc_addr_in == AIW'(k)) begin
                rd_sel[k] = 1'b1;
                sel_full  = ifull[k];
                sel_data  = ibuf[k];
            end
        end
    end

    // Read FSM. A request is evaluated fresh every cycle in IDLE and WAIT, so
    // the processor may change or drop it while stalled. TOUT is a single
    // non-stalled cycle returning zero data to release the processor.
    always_comb begin
        rd_next     = rd_state;
        cnt_next    = cnt;
        rd_stall    = 1'b0;
        rd_done     = 1'b0;
        rd_data     = '0;
        consume     = '0;
        rd_err_addr = 1'b0;
        rd_err_tmo  = 1'b0;
        case (rd_state)
            ST_IDLE, ST_WAIT: begin
                if (!proc_req_in) begin
                    rd_next = ST_IDLE;
                end else if (rd_sel == '0) begin
                    rd_err_addr = 1'b1;
                    rd_next     = ST_IDLE;
                end else if (sel_full) begin
                    rd_done = 1'b1;
                    rd_data = sel_data;
                    consume = rd_sel;
                    rd_next = ST_IDLE;
                end else if (rd_state == ST_IDLE) begin
                    rd_stall = 1'b1;
                    rd_next  = ST_WAIT;
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    rd_stall   = 1'b1;
                    rd_next    = ST_TOUT;
                    rd_err_tmo = 1'b1;
                    cnt_next   = cnt + CW'(1);
                end else begin
                    rd_stall = 1'b1;
                    cnt_next = cnt + CW'(1);
                end
            end
            default: rd_next = ST_IDLE;
        endcase
    end

    // Write acceptance: the target register is free if it is empty or is
    // being drained by the consumer in this same cycle.
    always_comb begin
        wr_acc      = '0;
        wr_hit      = 1'b0;
        wr_stall    = 1'b0;
        for (int k = 0; k < NUIOOU; k++) begin
            if (proc_addr_out == AOW'(k)) begin
                wr_hit = 1'b1;
                if (!out_valid[k] || out_ready[k]) begin
                    wr_acc[k] = proc_out_en;
                end else begin
                    wr_stall = proc_out_en;
                end
            end
        end
        wr_err_addr = proc_out_en && !wr_hit;
    end

    // Stall is forced low while reset is held so the processor is never
    // frozen by a request it issued into a block that is being cleared.
    assign proc_stall   = rst && (rd_stall || wr_stall);
    assign proc_data_in = rd_done ? rd_data : '0;
    assign in_ready     = ~ifull | consume;
    assign out_data     = obuf;

    // Read FSM, timeout counter and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= ST_IDLE;
            cnt      <= '0;
            req_in   <= '0;
            err_addr <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            rd_state <= rd_next;
            cnt      <= cnt_next;
            req_in   <= consume;
            err_addr <= err_addr | rd_err_addr | wr_err_addr;
            err_tmo  <= err_tmo | rd_err_tmo;
        end
    end

    // Input buffers: a refill in the consuming cycle keeps the entry full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ibuf  <= '0;
            ifull <= '0;
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (in_valid[k] && in_ready[k]) begin
                    ibuf[k]  <= in_data[k*NUBITS +: NUBITS];
                    ifull[k] <= 1'b1;
                end else if (consume[k]) begin
                    ifull[k] <= 1'b0;
                end
            end
        end
    end

    // Output registers: a new write wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            obuf      <= '0;
            out_valid <= '0;
            out_en    <= '0;
        end else begin
            out_en <= wr_acc;
            for (int k = 0; k < NUIOOU; k++) begin
                if (wr_acc[k]) begin
                    obuf[k]      <= proc_data_out;
                    out_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_port_ctrl
//
// Scoreboard bench for io_port_ctrl with three input channels, two output
// channels and a short read timeout. Stimulus pushes the expected read data,
// write pulses and output-channel words into queues; a monitor running on the
// falling edge pops and compares them as the design presents each response.
// ---------------------------------------------------------------------------
module tb_io_port_ctrl;

    localparam int NB  = 32;
    localparam int NI  = 3;
    localparam int NO  = 2;
    localparam int TM  = 8;
    localparam int AIW = 2;
    localparam int AOW = 1;

    typedef struct {
        logic [NB-1:0] data;
        logic [NI-1:0] req;
    } rd_exp_t;

    typedef struct {
        int            ch;
        logic [NB-1:0] data;
    } out_exp_t;

    logic                 clk;
    logic                 rst;
    logic                 proc_req_in;
    logic [AIW-1:0]       proc_addr_in;
    logic [NB-1:0]        proc_data_in;
    logic                 proc_out_en;
    logic [AOW-1:0]       proc_addr_out;
    logic [NB-1:0]        proc_data_out;
    logic                 proc_stall;
    logic [NI*NB-1:0]     in_data;
    logic [NI-1:0]        in_valid;
    logic [NI-1:0]        in_ready;
    logic [NO*NB-1:0]     out_data;
    logic [NO-1:0]        out_valid;
    logic [NO-1:0]        out_ready;
    logic [NI-1:0]        req_in;
    logic [NO-1:0]        out_en;
    logic                 err_addr;
    logic                 err_tmo;

    rd_exp_t              rd_q[$];
    logic [NO-1:0]        wr_q[$];
    out_exp_t             out_q[$];

    int checks = 0;
    int errors = 0;
    int stalls;
    int n;

    io_port_ctrl #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .TMO(TM)) dut (
        .clk(clk), .rst(rst),
        .proc_req_in(proc_req_in), .proc_addr_in(proc_addr_in),
        .proc_data_in(proc_data_in),
        .proc_out_en(proc_out_en), .proc_addr_out(proc_addr_out),
        .proc_data_out(proc_data_out), .proc_stall(proc_stall),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .req_in(req_in), .out_en(out_en),
        .err_addr(err_addr), .err_tmo(err_tmo)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never releases.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word on an empty input channel for a single cycle.
    task automatic apply_stimulus(input int ch, input logic [NB-1:0] d);
        in_data[ch*NB +: NB] = d;
        in_valid[ch] = 1'b1;
        tick();
        in_valid[ch] = 1'b0;
    endtask

    // Monitor: compares read data on every non-stalled read cycle, the
    // registered req_in pulse one cycle later, out_en pulses and every
    // output-channel transfer against the queued expectations.
    initial begin : monitor
        rd_exp_t       re;
        out_exp_t      oe;
        logic [NI-1:0] exp_req;
        logic [NO-1:0] we;
        exp_req = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_req = '0;
            end else begin
                check_output("req_in_pulse", 64'(req_in), 64'(exp_req));
                exp_req = '0;
                if (proc_stall) begin
                    check_output("data_zero_in_stall", 64'(proc_data_in), 64'd0);
                end
                if (proc_req_in && !proc_stall) begin
                    if (rd_q.size() == 0) begin
                        check_output("rd_unexpected", 64'(proc_data_in), 64'hDEAD_0000_0000);
                    end else begin
                        re = rd_q.pop_front();
                        check_output("rd_data", 64'(proc_data_in), 64'(re.data));
                        exp_req = re.req;
                    end
                end
                if (out_en != '0) begin
                    if (wr_q.size() == 0) begin
                        check_output("out_en_unexpected", 64'(out_en), 64'd0);
                    end else begin
                        we = wr_q.pop_front();
                        check_output("out_en_pulse", 64'(out_en), 64'(we));
                    end
                end
                for (int k = 0; k < NO; k++) begin
                    if (out_valid[k] && out_ready[k]) begin
                        if (out_q.size() == 0) begin
                            check_output("out_xfer_unexpected", 64'(k), 64'hFF);
                        end else begin
                            oe = out_q.pop_front();
                            check_output("out_xfer_ch", 64'(k), 64'(oe.ch));
                            check_output("out_xfer_data", 64'(out_data[k*NB +: NB]), 64'(oe.data));
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst           = 1'b0;
        proc_req_in   = 1'b0;
        proc_addr_in  = '0;
        proc_out_en   = 1'b0;
        proc_addr_out = '0;
        proc_data_out = '0;
        in_data       = '0;
        in_valid      = '0;
        out_ready     = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_stall", 64'(proc_stall), 64'd0);
        check_output("rst_in_ready", 64'(in_ready), 64'h7);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_req_in", 64'(req_in), 64'd0);
        check_output("rst_out_en", 64'(out_en), 64'd0);
        check_output("rst_errs", 64'({err_addr, err_tmo}), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Buffered word on channel 1 is returned in the request cycle.
        apply_stimulus(1, 32'h1234_5678);
        proc_req_in  = 1'b1;
        proc_addr_in = 2'd1;
        rd_q.push_back('{data: 32'h1234_5678, req: 3'b010});
        @(negedge clk);
        check_output("hit_stall", 64'(proc_stall), 64'd0);
        tick();
        proc_req_in = 1'b0;

        // Read an empty channel 0; data lands five cycles later.
        proc_req_in  = 1'b1;
        proc_addr_in = 2'd0;
        stalls = 0;
        rd_q.push_back('{data: 32'hA5A5_0001, req: 3'b001});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (proc_stall) stalls++;
            if (i == 4) begin
                in_data[0 +: NB] = 32'hA5A5_0001;
                in_valid[0] = 1'b1;
            end
            tick();
        end
        in_valid[0] = 1'b0;
        @(negedge clk);
        check_output("wait_stall_cycles", 64'(stalls), 64'd5);
        check_output("wait_release", 64'(proc_stall), 64'd0);
        tick();
        proc_req_in = 1'b0;

        // Dropping the request during WAIT abandons it without a timeout.
        proc_req_in  = 1'b1;
        proc_addr_in = 2'd2;
        @(negedge clk);
        check_output("abort_stall0", 64'(proc_stall), 64'd1);
        tick();
        @(negedge clk);
        check_output("abort_stall1", 64'(proc_stall), 64'd1);
        tick();
        proc_req_in = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        check_output("abort_no_tmo", 64'(err_tmo), 64'd0);
        tick();

        // Read of an empty channel times out after TM stalled cycles.
        proc_req_in  = 1'b1;
        proc_addr_in = 2'd0;
        stalls = 0;
        n = 0;
        rd_q.push_back('{data: 32'h0, req: 3'b000});
        @(negedge clk);
        while (proc_stall && n < 20) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        check_output("tmo_stall_cycles", 64'(stalls), 64'(TM));
        check_output("tmo_flag", 64'(err_tmo), 64'd1);
        tick();
        proc_req_in = 1'b0;

        // Two writes to channel 0 while its consumer is not ready.
        proc_out_en   = 1'b1;
        proc_addr_out = 1'b0;
        proc_data_out = 32'h1111_AAAA;
        wr_q.push_back(2'b01);
        @(negedge clk);
        check_output("wr1_stall", 64'(proc_stall), 64'd0);
        tick();
        proc_data_out = 32'h2222_BBBB;
        @(negedge clk);
        check_output("wr2_stall_a", 64'(proc_stall), 64'd1);
        tick();
        @(negedge clk);
        check_output("wr2_stall_b", 64'(proc_stall), 64'd1);
        tick();
        out_ready[0] = 1'b1;
        out_q.push_back('{ch: 0, data: 32'h1111_AAAA});
        wr_q.push_back(2'b01);
        @(negedge clk);
        check_output("wr2_accept", 64'(proc_stall), 64'd0);
        tick();
        proc_out_en  = 1'b0;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check_output("wr2_data", 64'(out_data[0 +: NB]), 64'h2222_BBBB);
        check_output("wr2_valid", 64'(out_valid[0]), 64'd1);
        tick();
        out_ready[0] = 1'b1;
        out_q.push_back('{ch: 0, data: 32'h2222_BBBB});
        tick();
        out_ready[0] = 1'b0;
        @(negedge clk);
        check_output("drain_valid", 64'(out_valid), 64'd0);
        tick();

        // Read of a channel index past the last input channel.
        proc_req_in  = 1'b1;
        proc_addr_in = 2'd3;
        rd_q.push_back('{data: 32'h0, req: 3'b000});
        @(negedge clk);
        check_output("badaddr_stall", 64'(proc_stall), 64'd0);
        tick();
        proc_req_in = 1'b0;
        @(negedge clk);
        check_output("badaddr_flag", 64'(err_addr), 64'd1);
        check_output("badaddr_in_ready", 64'(in_ready), 64'h7);
        tick();

        // Read and write completing together.
        apply_stimulus(2, 32'h0BAD_F00D);
        proc_req_in   = 1'b1;
        proc_addr_in  = 2'd2;
        proc_out_en   = 1'b1;
        proc_addr_out = 1'b1;
        proc_data_out = 32'h3333_CCCC;
        rd_q.push_back('{data: 32'h0BAD_F00D, req: 3'b100});
        wr_q.push_back(2'b10);
        @(negedge clk);
        check_output("both_stall", 64'(proc_stall), 64'd0);
        tick();
        proc_req_in = 1'b0;
        proc_out_en = 1'b0;
        @(negedge clk);
        check_output("both_out_data", 64'(out_data[NB +: NB]), 64'h3333_CCCC);
        check_output("both_out_valid", 64'(out_valid), 64'h2);
        tick();

        // Reset in the middle of a stalled read with another buffer full.
        apply_stimulus(1, 32'hCAFE_0001);
        proc_req_in  = 1'b1;
        proc_addr_in = 2'd0;
        tick();
        tick();
        @(negedge clk);
        check_output("pre_rst_stall", 64'(proc_stall), 64'd1);
        rst = 1'b0;
        #1;
        check_output("mid_rst_stall", 64'(proc_stall), 64'd0);
        check_output("mid_rst_in_ready", 64'(in_ready), 64'h7);
        check_output("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_output("mid_rst_pulses", 64'({req_in, out_en}), 64'd0);
        check_output("mid_rst_errs", 64'({err_addr, err_tmo}), 64'd0);
        check_output("mid_rst_out_data", 64'(out_data), 64'd0);
        proc_req_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_output("post_rst_in_ready", 64'(in_ready), 64'h7);
        check_output("post_rst_stall", 64'(proc_stall), 64'd0);
        tick();

        // Every queued expectation must have been observed.
        repeat (3) tick();
        check_output("rd_q_left", 64'(rd_q.size()), 64'd0);
        check_output("wr_q_left", 64'(wr_q.size()), 64'd0);
        check_output("out_q_left", 64'(out_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
